// File: rtl/sort4_pkg.sv
// Shared types and constants for the sequential 4-input descending sorter.
// The step table encodes the 5-comparator optimal network for four inputs.
package sort4_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned STEPS = 5;

   localparam logic [1:0] STEP_I [0:4] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd1};
   localparam logic [1:0] STEP_J [0:4] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd2};

   localparam logic [7:0] IDX_IDENT = 8'hE4;

   // Steps beyond the last entry are never reached; clamp so the lookup stays in range.
   function automatic logic [1:0] step_i(input logic [2:0] s);
      return (s > 3'd4) ? STEP_I[4] : STEP_I[s];
   endfunction

   function automatic logic [1:0] step_j(input logic [2:0] s);
      return (s > 3'd4) ? STEP_J[4] : STEP_J[s];
   endfunction

endpackage

// File: rtl/sort4_seq_sched_cmp_xchg.sv
// Single compare-exchange unit: larger value to hi, ties keep x on the hi side.
module cmp_xchg #(
   parameter int W = 16
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [1:0]   x_idx,
   input  logic [1:0]   y_idx,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic [1:0]   hi_idx,
   output logic [1:0]   lo_idx,
   output logic         swapped
);

   // Strict unsigned greater-than keeps the sort stable on equal values.
   assign swapped = (y > x);
   assign hi      = swapped ? y : x;
   assign lo      = swapped ? x : y;
   assign hi_idx  = swapped ? y_idx : x_idx;
   assign lo_idx  = swapped ? x_idx : y_idx;

endmodule

// File: rtl/sort4_seq_sched.sv
// Time-shared 4-input descending sorter: one compare-exchange per cycle
// through the 5-step network, result held until the consumer accepts it.
//
//   state | meaning
//   IDLE  | waiting for an input set, in_ready high
//   CMP   | running compare-exchange step 'step' (0..4)
//   DONE  | sorted result on outputs, out_valid high until accepted
module sort4_seq_sched
   import sort4_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [W-1:0] in_c,
   input  logic [W-1:0] in_d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_y0,
   output logic [W-1:0] out_y1,
   output logic [W-1:0] out_y2,
   output logic [W-1:0] out_y3,
   output logic [7:0]   out_sel,
   output logic [2:0]   swap_cnt,
   output logic         busy
);

   state_t       state, state_nxt;
   logic [2:0]   step, step_nxt;
   logic [W-1:0] d [4];
   logic [W-1:0] d_nxt [4];
   logic [1:0]   idx [4];
   logic [1:0]   idx_nxt [4];
   logic [2:0]   cnt_nxt;
   logic         load_out;

   logic [1:0]   pi, pj;
   logic [W-1:0] cx_hi, cx_lo;
   logic [1:0]   cx_hi_idx, cx_lo_idx;
   logic         cx_swapped;

   assign pi = step_i(step);
   assign pj = step_j(step);

   cmp_xchg #(.W(W)) u_cmp_xchg (
      .x       (d[pi]),
      .y       (d[pj]),
      .x_idx   (idx[pi]),
      .y_idx   (idx[pj]),
      .hi      (cx_hi),
      .lo      (cx_lo),
      .hi_idx  (cx_hi_idx),
      .lo_idx  (cx_lo_idx),
      .swapped (cx_swapped)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == CMP) || (state == DONE);

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      d_nxt     = d;
      idx_nxt   = idx;
      cnt_nxt   = swap_cnt;
      load_out  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               d_nxt[0]  = in_a;
               d_nxt[1]  = in_b;
               d_nxt[2]  = in_c;
               d_nxt[3]  = in_d;
               idx_nxt[0] = 2'd0;
               idx_nxt[1] = 2'd1;
               idx_nxt[2] = 2'd2;
               idx_nxt[3] = 2'd3;
               cnt_nxt   = 3'd0;
               step_nxt  = 3'd0;
               state_nxt = CMP;
            end
         end
         CMP: begin
            if (step > 3'd4) begin
               state_nxt = DONE;
            end else begin
               d_nxt[pi]   = cx_hi;
               d_nxt[pj]   = cx_lo;
               idx_nxt[pi] = cx_hi_idx;
               idx_nxt[pj] = cx_lo_idx;
               cnt_nxt     = swap_cnt + {2'b00, cx_swapped};
               step_nxt    = step + 3'd1;
               if (step == 3'd4) begin
                  state_nxt = DONE;
                  load_out  = 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         step     <= 3'd0;
         d        <= '{default: '0};
         idx      <= '{2'd0, 2'd1, 2'd2, 2'd3};
         swap_cnt <= 3'd0;
         out_y0   <= '0;
         out_y1   <= '0;
         out_y2   <= '0;
         out_y3   <= '0;
         out_sel  <= IDX_IDENT;
      end else begin
         state    <= state_nxt;
         step     <= step_nxt;
         d        <= d_nxt;
         idx      <= idx_nxt;
         swap_cnt <= cnt_nxt;
         // Output words change only when a finished sort lands, so they hold across IDLE.
         if (load_out) begin
            out_y0  <= d_nxt[0];
            out_y1  <= d_nxt[1];
            out_y2  <= d_nxt[2];
            out_y3  <= d_nxt[3];
            out_sel <= {idx_nxt[3], idx_nxt[2], idx_nxt[1], idx_nxt[0]};
         end
      end
   end

endmodule

// File: tb/tb_sort4_seq_sched.sv
// Directed bench for sort4_seq_sched: hand-computed sort results, latency,
// backpressure and mid-sort reset.
module tb_sort4_seq_sched;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a, in_b, in_c, in_d;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_y0, out_y1, out_y2, out_y3;
   logic [7:0]  out_sel;
   logic [2:0]  swap_cnt;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   sort4_seq_sched #(.W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .in_d      (in_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y0    (out_y0),
      .out_y1    (out_y1),
      .out_y2    (out_y2),
      .out_y3    (out_y3),
      .out_sel   (out_sel),
      .swap_cnt  (swap_cnt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshake one set, measure latency, check the result, then accept it.
   task automatic run_sort(input string name,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input logic [7:0] esel, input logic [2:0] ecnt);
      int n;
      check({name, "_pre_in_ready"}, in_ready, 1);
      in_a = a; in_b = b; in_c = c; in_d = d;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check({name, "_hs_in_ready"}, in_ready, 0);
      check({name, "_hs_busy"}, busy, 1);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check({name, "_latency"}, n, 5);
      check({name, "_y0"}, out_y0, e0);
      check({name, "_y1"}, out_y1, e1);
      check({name, "_y2"}, out_y2, e2);
      check({name, "_y3"}, out_y3, e3);
      check({name, "_sel"}, out_sel, esel);
      check({name, "_swaps"}, swap_cnt, ecnt);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_post_valid"}, out_valid, 0);
      check({name, "_post_in_ready"}, in_ready, 1);
      check({name, "_post_y0_held"}, out_y0, e0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_c = '0; in_d = '0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_y0", out_y0, 0);
      check("rst_y3", out_y3, 0);
      check("rst_sel", out_sel, 8'hE4);
      check("rst_swaps", swap_cnt, 0);
      rst_n = 1'b1;
      tick();

      // Reverse order: four exchanges (the final (1,2) pair is already ordered).
      run_sort("rev", 16'd1, 16'd2, 16'd3, 16'd4,
               16'd4, 16'd3, 16'd2, 16'd1, 8'b00_01_10_11, 3'd4);
      run_sort("sorted", 16'd9, 16'd7, 16'd5, 16'd3,
               16'd9, 16'd7, 16'd5, 16'd3, 8'hE4, 3'd0);
      run_sort("equal", 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA,
               16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 8'hE4, 3'd0);
      run_sort("extreme", 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF,
               16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 8'b00_11_10_01, 3'd3);

      // Backpressure: 3,9,1,7 -> 9,7,3,1, origins {2,0,3,1}, three exchanges.
      in_a = 16'd3; in_b = 16'd9; in_c = 16'd1; in_d = 16'd7;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check("bp_latency", n, 5);
      in_a = 16'h1111; in_b = 16'h2222; in_c = 16'h3333; in_d = 16'h4444;
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("bp_valid_hold", out_valid, 1);
         check("bp_in_ready_low", in_ready, 0);
         check("bp_y0_stable", out_y0, 16'd9);
         check("bp_y3_stable", out_y3, 16'd1);
         check("bp_sel_stable", out_sel, 8'h8D);
      end
      check("bp_y1", out_y1, 16'd7);
      check("bp_y2", out_y2, 16'd3);
      check("bp_swaps", swap_cnt, 3'd3);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_rel_valid", out_valid, 0);
      check("bp_rel_in_ready", in_ready, 1);
      check("bp_rel_y0", out_y0, 16'd9);
      tick();
      check("bp_idle_stays", in_ready, 1);
      check("bp_idle_busy", busy, 0);

      // Reset while step 2 is pending.
      in_a = 16'd1; in_b = 16'd2; in_c = 16'd3; in_d = 16'd4;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_in_ready", in_ready, 1);
      check("mrst_valid", out_valid, 0);
      check("mrst_busy", busy, 0);
      check("mrst_swaps", swap_cnt, 0);
      check("mrst_sel", out_sel, 8'hE4);
      check("mrst_y0", out_y0, 0);
      tick();
      check("mrst_no_output", out_valid, 0);

      // 4,1,3,2: exchanges at steps 3 and 4, origins {1,3,2,0}.
      run_sort("after_rst", 16'd4, 16'd1, 16'd3, 16'd2,
               16'd4, 16'd3, 16'd2, 16'd1, 8'b01_11_10_00, 3'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
